// File: rtl/fetch_unit_pkg.sv
// Shared core constants and types for the instruction fetch unit.
// Holds the fetch FSM state encoding and the default reset vector / PC step.
// Imported by fetch_unit and by anything that needs to decode its state.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0100_0000;
  localparam int unsigned PC_STEP_DEF      = 4;

  // Cycles after reset release during which a leftover memory response is discarded.
  localparam logic [2:0]  RST_GUARD_CYCLES = 3'd4;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Purpose: single-outstanding instruction fetch FSM between PC register, imem and decode.
// Latency: imem_req one cycle after the PC load; if_valid the cycle after imem_rvalid.
// Backpressure: if_valid/if_instr/if_pc hold until if_ready; no new fetch while holding.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int unsigned PC_STEP      = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [2:0]   guard_q, guard_d;
  logic         stale_q, stale_d;

  logic         pc_en_c;
  logic [31:0]  pc_next_c;
  logic         imem_req_c;
  logic         stale_pending;
  logic         rvalid_eff;
  logic         outstanding;
  logic [31:0]  redirect_tgt;

  // A response left over from before reset is only expected inside the guard window.
  assign stale_pending = stale_q && (guard_q != 3'd0);
  assign rvalid_eff    = imem_rvalid && !stale_pending;
  assign outstanding   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign redirect_tgt  = align_word(redirect_pc);

  // Fetch FSM: next state, PC load strobe, memory request and decode-side capture.
  always_comb begin
    state_d    = state_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    pc_en_c    = 1'b0;
    pc_next_c  = RESET_VECTOR;
    imem_req_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pc_en_c    = 1'b1;
        pc_next_c  = redirect ? redirect_tgt : RESET_VECTOR;
        if_valid_d = 1'b0;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        // A redirect here suppresses the request so the stale PC never reaches imem.
        if (redirect) begin
          pc_en_c   = 1'b1;
          pc_next_c = redirect_tgt;
        end else if (!stale_pending) begin
          imem_req_c = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_en_c    = 1'b1;
          pc_next_c  = redirect_tgt;
          if_valid_d = 1'b0;
          state_d    = rvalid_eff ? ST_REQ : ST_DRAIN;
        end else if (rvalid_eff) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_in;
          if_valid_d = 1'b1;
          pc_en_c    = 1'b1;
          pc_next_c  = pc_in + STEP;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirect takes priority over a simultaneous decode handshake.
        if (redirect) begin
          pc_en_c    = 1'b1;
          pc_next_c  = redirect_tgt;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // If the dropped response lands together with a new redirect, nothing is left in flight.
        if (redirect) begin
          pc_en_c   = 1'b1;
          pc_next_c = redirect_tgt;
          state_d   = rvalid_eff ? ST_REQ : ST_DRAIN;
        end else if (rvalid_eff) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) begin
      state_d    = ST_IDLE;
      if_valid_d = 1'b0;
      if_instr_d = '0;
      if_pc_d    = '0;
      pc_en_c    = 1'b0;
      pc_next_c  = RESET_VECTOR;
      imem_req_c = 1'b0;
    end
  end

  // Post-reset guard: remember an abandoned request and swallow its response if it shows up soon.
  always_comb begin
    guard_d = guard_q;
    stale_d = stale_q;
    if (rst) begin
      guard_d = RST_GUARD_CYCLES;
      stale_d = (stale_pending || outstanding) && !imem_rvalid;
    end else begin
      guard_d = (guard_q != 3'd0) ? guard_q - 3'd1 : 3'd0;
      stale_d = stale_pending && !imem_rvalid;
    end
  end

  // State and decode-side registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    if_valid_q <= if_valid_d;
    if_instr_q <= if_instr_d;
    if_pc_q    <= if_pc_d;
    guard_q    <= guard_d;
    stale_q    <= stale_d;
  end

  assign pc_en     = pc_en_c;
  assign pc_next   = pc_next_c;
  assign imem_req  = imem_req_c;
  assign imem_addr = pc_in;
  assign if_valid  = if_valid_q && !rst;
  assign if_instr  = rst ? 32'h0 : if_instr_q;
  assign if_pc     = rst ? 32'h0 : if_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, directed corner sequences, random run vs model.
// Inputs driven on the falling edge; outputs compared 1 ns later.
// The bench models the program counter register and the instruction memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RV = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, imem_rvalid, if_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic [31:0] pc_q = 32'h0;
  logic        pc_en, imem_req, if_valid;
  logic [31:0] pc_next, imem_addr, if_instr, if_pc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_q), .pc_en(pc_en), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  // Program counter register fed by the fetch unit.
  always @(posedge clk) if (pc_en) pc_q <= pc_next;

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: run did not reach its end");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rp,
                       input logic v, input logic [31:0] d, input logic y);
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rp; imem_rvalid = v; imem_rdata = d; if_ready = y;
    #1;
  endtask

  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_pcen;
    logic [31:0] e_pcnext;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifpc, e_ifinstr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                              input logic v, input logic [31:0] d, input logic y,
                              input logic epe, input logic [31:0] epn, input logic erq,
                              input logic [31:0] ead, input logic eiv,
                              input logic [31:0] eip, input logic [31:0] eii);
    vec_t t;
    t.rst = r; t.redir = rd; t.rpc = rp; t.rv = v; t.rd = d; t.rdy = y;
    t.e_pcen = epe; t.e_pcnext = epn; t.e_req = erq; t.e_addr = ead;
    t.e_ifv = eiv; t.e_ifpc = eip; t.e_ifinstr = eii;
    return t;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [31:0] i1 = 32'h1111_0001, i2 = 32'h2222_0002, i3 = 32'h3333_0003;
    logic [31:0] i4 = 32'h4444_0004, i5 = 32'h5555_0005, junk = 32'h5A5A_5A5A;
    // random-phase model state
    bit          out_r = 0, killed = 0, mv = 0, rdir, rdy, rv, good;
    int          cnt = 0, idle_cyc = 0, delivered = 0;
    logic [31:0] req_a = 32'h0, mi = 32'h0, mp = 32'h0, exp_pc, tgt, d;

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;

    //            rst rd rpc rv rdata rdy | pc_en pc_next req addr ifv if_pc if_instr
    tbl.push_back(mk(1, 0, 0, 0, 0,    0,   0, RV,     0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,    0,   0, RV,     0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   1, RV,     0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      1, RV, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, i1,   0,   1, RV+4,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 1, junk, 0,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1,   0, 0,      0, 0, 1, RV, i1));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      1, RV+4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, i2,   0,   1, RV+8,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,    1,   0, 0,      0, 0, 1, RV+4, i2));
    tbl.push_back(mk(0, 0, 0, 0, 0,    0,   0, 0,      1, RV+8, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
      chk($sformatf("vec%0d pc_en", i), pc_en, tbl[i].e_pcen);
      if (tbl[i].e_pcen || tbl[i].rst) chk($sformatf("vec%0d pc_next", i), pc_next, tbl[i].e_pcnext);
      chk($sformatf("vec%0d imem_req", i), imem_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d if_valid", i), if_valid, tbl[i].e_ifv);
      if (tbl[i].e_ifv || tbl[i].rst) begin
        chk($sformatf("vec%0d if_pc", i), if_pc, tbl[i].e_ifpc);
        chk($sformatf("vec%0d if_instr", i), if_instr, tbl[i].e_ifinstr);
      end
    end

    // Redirect while waiting; the late response must be dropped.
    drive(0, 1, 32'h0100_0103, 0, 0, 0);
    chk("wait_redir pc_en", pc_en, 1);
    chk("wait_redir pc_next", pc_next, 32'h0100_0100);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("drain pc_en", pc_en, 0);
      chk("drain imem_req", imem_req, 0);
      chk("drain if_valid", if_valid, 0);
    end
    drive(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("drain_resp pc_en", pc_en, 0);
    chk("drain_resp if_valid", if_valid, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("after_drain imem_req", imem_req, 1);
    chk("after_drain imem_addr", imem_addr, 32'h0100_0100);
    chk("no_deadbeef", if_instr == 32'hDEAD_BEEF, 0);
    drive(0, 0, 0, 1, i3, 0);
    chk("resp3 pc_next", pc_next, 32'h0100_0104);

    // Redirect and if_ready together in HOLD.
    drive(0, 1, 32'h0200_0000, 0, 0, 1);
    chk("hold_redir if_instr", if_instr, i3);
    chk("hold_redir pc_en", pc_en, 1);
    chk("hold_redir pc_next", pc_next, 32'h0200_0000);
    drive(0, 0, 0, 0, 0, 0);
    chk("post_redir if_valid", if_valid, 0);
    chk("post_redir imem_req", imem_req, 1);
    chk("post_redir imem_addr", imem_addr, 32'h0200_0000);

    // Redirect in WAIT, second redirect in DRAIN, then PC wrap at the top of memory.
    drive(0, 1, 32'hFFFF_FFF0, 0, 0, 0);
    chk("redir_a pc_next", pc_next, 32'hFFFF_FFF0);
    drive(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    chk("drain_redir pc_en", pc_en, 1);
    chk("drain_redir pc_next", pc_next, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, junk, 0);
    chk("drain_rv pc_en", pc_en, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("top_req imem_addr", imem_addr, 32'hFFFF_FFFC);
    chk("top_req imem_req", imem_req, 1);
    drive(0, 0, 0, 1, i4, 0);
    chk("wrap pc_next", pc_next, 32'h0000_0000);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap if_instr", if_instr, i4);
    drive(0, 0, 0, 0, 0, 0);
    chk("wrap_next imem_addr", imem_addr, 32'h0000_0000);

    // Reset while waiting; response two cycles after release must be ignored.
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_wait pc_en", pc_en, 0);
    chk("rst_wait imem_req", imem_req, 0);
    chk("rst_wait pc_next", pc_next, RV);
    chk("rst_wait if_valid", if_valid, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_rel pc_en", pc_en, 1);
    chk("rst_rel pc_next", pc_next, RV);
    drive(0, 0, 0, 0, 0, 0);
    chk("guard imem_req", imem_req, 0);
    drive(0, 0, 0, 1, 32'hBADB_AD00, 0);
    chk("stale pc_en", pc_en, 0);
    chk("stale imem_req", imem_req, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("restart imem_req", imem_req, 1);
    chk("restart imem_addr", imem_addr, RV);
    drive(0, 0, 0, 1, i5, 0);
    chk("restart pc_next", pc_next, RV + 4);
    drive(0, 0, 0, 0, 0, 1);
    chk("restart if_valid", if_valid, 1);
    chk("restart if_instr", if_instr, i5);
    chk("restart if_pc", if_pc, RV);

    // Random traffic against a transaction-level model.
    exp_pc = RV + 4;
    for (int c = 0; c < 1500; c++) begin
      rdir = ($urandom_range(0, 99) < 8);
      tgt  = $urandom;
      rdy  = $urandom_range(0, 1);
      d    = $urandom;
      rv   = 0;
      if (out_r) begin
        cnt--;
        rv = (cnt == 0);
      end else if ($urandom_range(0, 99) < 5) begin
        rv = 1;
      end
      drive(0, rdir, tgt, rv, d, rdy);

      good = rv && out_r && !killed && !rdir;
      chk("rnd pc_en", pc_en, rdir || good);
      if (rdir)      chk("rnd pc_next_redir", pc_next, tgt & 32'hFFFF_FFFC);
      else if (good) chk("rnd pc_next_seq", pc_next, req_a + 32'd4);
      chk("rnd if_valid", if_valid, mv);
      if (mv) begin
        chk("rnd if_instr", if_instr, mi);
        chk("rnd if_pc", if_pc, mp);
      end
      if (imem_req) begin
        chk("rnd req_legal", out_r || rdir || mv, 0);
        chk("rnd imem_addr", imem_addr, exp_pc);
        idle_cyc = 0;
      end else begin
        idle_cyc++;
        if (idle_cyc > 40) begin
          n_chk++;
          n_fail++;
          $display("FAIL rnd progress: no imem_req for %0d cycles, required at most 40", idle_cyc);
          break;
        end
      end

      if (rv && out_r) out_r = 0;
      if (imem_req) begin
        out_r  = 1;
        req_a  = exp_pc;
        killed = 0;
        cnt    = $urandom_range(1, 4);
      end
      if (rdir) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
        mv     = 0;
        if (out_r) killed = 1;
      end else if (good) begin
        mv     = 1;
        mi     = d;
        mp     = req_a;
        exp_pc = req_a + 32'd4;
        delivered++;
      end else if (mv && rdy) begin
        mv = 0;
      end
    end
    chk("rnd delivered_min", delivered >= 20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
